oc_dispatch_arbiter: RTL

- Issue-stage arbiter between the four operand collector units (OCs) and the execution units.
- Each cycle it selects at most one fully-collected OC for the ALU and at most one for the MEM unit, round-robin per unit.
- Drives the one-hot ALU_Grt/MEM_Grt selects of the ALU/MEM dispatch mux and returns release pulses to the OCs.
- Honours MEM back-pressure.

---
 rtl/gpu_oc_pkg.sv | 18 +
 rtl/oc_dispatch_arbiter_rr_pick.sv | 28 ++
 rtl/oc_dispatch_arbiter.sv | 72 +++++++
 3 files changed

// File: rtl/gpu_oc_pkg.sv
// Shared operand-collector types: OC count, one-hot select and RR pointer types.
package gpu_oc_pkg;
   localparam int NUM_OC   = 4;
   localparam int OC_IDX_W = 2;

   typedef logic [NUM_OC-1:0]   oc_onehot_t;
   typedef logic [OC_IDX_W-1:0] oc_ptr_t;

   // next round-robin start index, wrapping at NUM_OC
   function automatic oc_ptr_t ptr_next(input oc_ptr_t p);
      return (p == oc_ptr_t'(NUM_OC-1)) ? '0 : p + oc_ptr_t'(1);
   endfunction

   // saturating 32-bit increment for the performance counters
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/oc_dispatch_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index scanning up from ptr.
module rr_pick
   import gpu_oc_pkg::*;
(
   input  logic [NUM_OC-1:0]   elig,
   input  logic [OC_IDX_W-1:0] ptr,
   output logic [NUM_OC-1:0]   grant,
   output logic [OC_IDX_W-1:0] win
);
   oc_ptr_t idx;
   logic    found;

   // scan ptr, ptr+1, ... mod NUM_OC and keep the first hit
   always_comb begin
      grant = '0;
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_OC; k++) begin
         idx = oc_ptr_t'((int'(ptr) + k) % NUM_OC);
         if (!found && elig[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win        = idx;
         end
      end
   end
endmodule

// File: rtl/oc_dispatch_arbiter.sv
// Issue-stage arbiter: one ALU and one MEM dispatch per cycle, round-robin per unit.
// Optional feature macro: ARB_PERF_CNT_EN adds saturating issue/stall counters.
module oc_dispatch_arbiter
   import gpu_oc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_OC-1:0] OC_Ready,
   input  logic [NUM_OC-1:0] OC_IsMem,
   input  logic              MEM_Stall,
   output logic [NUM_OC-1:0] ALU_Grt,
   output logic [NUM_OC-1:0] MEM_Grt,
   output logic              ALU_Fire,
   output logic              MEM_Fire,
`ifdef ARB_PERF_CNT_EN
   output logic [NUM_OC-1:0] OC_Release,
   output logic [31:0]       Perf_ALU_Issue_Cnt,
   output logic [31:0]       Perf_MEM_Issue_Cnt,
   output logic [31:0]       Perf_MEM_Stall_Cnt
`else
   output logic [NUM_OC-1:0] OC_Release
`endif
);
   oc_onehot_t alu_elig, mem_elig, alu_pick, mem_pick;
   oc_ptr_t    alu_ptr, mem_ptr, alu_win, mem_win;
   logic       mem_hold;

   // an OC being released this cycle is masked so it cannot be re-granted next cycle
   assign alu_elig = OC_Ready & ~OC_IsMem & ~ALU_Grt;
   assign mem_elig = OC_Ready &  OC_IsMem & ~MEM_Grt;
   assign mem_hold = (|MEM_Grt) & MEM_Stall;

   rr_pick u_alu_pick (.elig(alu_elig), .ptr(alu_ptr), .grant(alu_pick), .win(alu_win));
   rr_pick u_mem_pick (.elig(mem_elig), .ptr(mem_ptr), .grant(mem_pick), .win(mem_win));

   // grants are gated during reset so a grant dropped by rst never reads as consumed
   assign ALU_Fire   = ~rst & (|ALU_Grt);
   assign MEM_Fire   = ~rst & (|MEM_Grt) & ~MEM_Stall;
   assign OC_Release = rst ? '0 : (ALU_Grt | (MEM_Grt & {NUM_OC{~MEM_Stall}}));

   // grant registers and round-robin pointers; a stalled MEM grant holds in place
   always_ff @(posedge clk) begin
      if (rst) begin
         ALU_Grt <= '0;
         MEM_Grt <= '0;
         alu_ptr <= '0;
         mem_ptr <= '0;
      end else begin
         ALU_Grt <= alu_pick;
         if (|alu_pick) alu_ptr <= ptr_next(alu_win);
         if (!mem_hold) begin
            MEM_Grt <= mem_pick;
            if (|mem_pick) mem_ptr <= ptr_next(mem_win);
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   // saturating issue and stall counters
   always_ff @(posedge clk) begin
      if (rst) begin
         Perf_ALU_Issue_Cnt <= '0;
         Perf_MEM_Issue_Cnt <= '0;
         Perf_MEM_Stall_Cnt <= '0;
      end else begin
         if (ALU_Fire) Perf_ALU_Issue_Cnt <= sat_inc(Perf_ALU_Issue_Cnt);
         if (MEM_Fire) Perf_MEM_Issue_Cnt <= sat_inc(Perf_MEM_Issue_Cnt);
         if (mem_hold) Perf_MEM_Stall_Cnt <= sat_inc(Perf_MEM_Stall_Cnt);
      end
   end
`endif
endmodule
